// File: rtl/fpu_pkg.sv
// Shared constants and FSM encoding for the FPU issue queue.
package fpu_pkg;

    localparam int unsigned FP_W = 32;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } iq_state_e;

endpackage

// File: rtl/fpu_req_fifo.sv
// Synchronous request FIFO; pointers carry a wrap bit to tell full from empty.
module fpu_req_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 70
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [AW:0]      wptr_q, rptr_q;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
    assign count_o = wptr_q - rptr_q;

endmodule

// File: rtl/fpu_issue_queue.sv
// Buffers tagged FPU requests and issues them one at a time via start/busy/done.
module fpu_issue_queue
    import fpu_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter int unsigned TagW    = 4,
    parameter int unsigned Timeout = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [1:0]              req_op_i,
    input  logic [FP_W-1:0]         req_a_i,
    input  logic [FP_W-1:0]         req_b_i,
    input  logic [TagW-1:0]         req_tag_i,
    output logic                    fpu_rst_o,
    output logic                    fpu_start_o,
    output logic [1:0]              fpu_operation_o,
    output logic [FP_W-1:0]         fpu_a_o,
    output logic [FP_W-1:0]         fpu_b_o,
    input  logic                    fpu_busy_i,
    input  logic                    fpu_done_i,
    input  logic [FP_W-1:0]         fpu_z_i,
    input  logic                    fpu_ovf_i,
    input  logic                    fpu_unf_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [FP_W-1:0]         rsp_z_o,
    output logic [TagW-1:0]         rsp_tag_o,
    output logic                    rsp_ovf_o,
    output logic                    rsp_unf_o,
    output logic                    rsp_err_o,
    output logic [$clog2(Depth):0]  count_o
);

    localparam int unsigned EntryW  = 2 + 2 * FP_W + TagW;
    localparam logic [7:0]  TmoLast = 8'(Timeout - 1);

    iq_state_e         state_q, state_d;
    logic              first_q, first_d;
    logic [7:0]        tmo_q, tmo_d;
    logic [1:0]        op_q, op_d;
    logic [FP_W-1:0]   a_q, a_d, b_q, b_d;
    logic [TagW-1:0]   tag_q, tag_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [FP_W-1:0]   rsp_z_q, rsp_z_d;
    logic [TagW-1:0]   rsp_tag_q, rsp_tag_d;
    logic              rsp_ovf_q, rsp_ovf_d, rsp_unf_q, rsp_unf_d, rsp_err_q, rsp_err_d;

    logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [EntryW-1:0] fifo_wdata, fifo_rdata;

    assign fifo_push  = req_valid_i && !fifo_full;
    assign fifo_wdata = {req_op_i, req_a_i, req_b_i, req_tag_i};

    fpu_req_fifo #(
        .Depth (Depth),
        .Width (EntryW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    always_comb begin
        state_d     = state_q;
        first_d     = 1'b0;
        tmo_d       = tmo_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        tag_d       = tag_q;
        rsp_valid_d = rsp_valid_q;
        rsp_z_d     = rsp_z_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_unf_d   = rsp_unf_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop    = 1'b0;
        fpu_start_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Busy still high here means a timed-out op is draining; hold off.
                if (!fifo_empty && !rsp_valid_q && !fpu_busy_i) begin
                    {op_d, a_d, b_d, tag_d} = fifo_rdata;
                    fifo_pop = 1'b1;
                    first_d  = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                fpu_start_o = 1'b1;
                if (fpu_busy_i && !first_q) begin
                    tmo_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (fpu_done_i && !fpu_busy_i) begin
                    rsp_z_d     = fpu_z_i;
                    rsp_ovf_d   = fpu_ovf_i;
                    rsp_unf_d   = fpu_unf_i;
                    rsp_err_d   = 1'b0;
                    rsp_tag_d   = tag_q;
                    rsp_valid_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = StResp;
                end else if (tmo_q == TmoLast) begin
                    rsp_z_d     = QNAN;
                    rsp_ovf_d   = 1'b0;
                    rsp_unf_d   = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_tag_d   = tag_q;
                    rsp_valid_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = StResp;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            first_q     <= 1'b0;
            tmo_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_z_q     <= '0;
            rsp_tag_q   <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_unf_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            tmo_q       <= tmo_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_z_q     <= rsp_z_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_unf_q   <= rsp_unf_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign fpu_rst_o       = !rst_ni;
    assign req_ready_o     = !fifo_full;
    assign fpu_operation_o = op_q;
    assign fpu_a_o         = a_q;
    assign fpu_b_o         = b_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_z_o         = rsp_z_q;
    assign rsp_tag_o       = rsp_tag_q;
    assign rsp_ovf_o       = rsp_ovf_q;
    assign rsp_unf_o       = rsp_unf_q;
    assign rsp_err_o       = rsp_err_q;

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Scoreboard bench for fpu_issue_queue with a behavioural multi-cycle FPU model.
module tb_fpu_issue_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [31:0] req_a = '0, req_b = '0;
    logic [3:0]  req_tag = '0;
    logic        fpu_rst, fpu_start;
    logic [1:0]  fpu_op;
    logic [31:0] fpu_a, fpu_b;
    logic        fpu_busy, fpu_done;
    logic [31:0] fpu_z;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_z;
    logic [3:0]  rsp_tag;
    logic        rsp_ovf, rsp_unf, rsp_err;
    logic [2:0]  count;

    always #5 clk = ~clk;

    fpu_issue_queue u_dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_op_i        (req_op),
        .req_a_i         (req_a),
        .req_b_i         (req_b),
        .req_tag_i       (req_tag),
        .fpu_rst_o       (fpu_rst),
        .fpu_start_o     (fpu_start),
        .fpu_operation_o (fpu_op),
        .fpu_a_o         (fpu_a),
        .fpu_b_o         (fpu_b),
        .fpu_busy_i      (fpu_busy),
        .fpu_done_i      (fpu_done),
        .fpu_z_i         (fpu_z),
        .fpu_ovf_i       (1'b0),
        .fpu_unf_i       (1'b0),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_z_o         (rsp_z),
        .rsp_tag_o       (rsp_tag),
        .rsp_ovf_o       (rsp_ovf),
        .rsp_unf_o       (rsp_unf),
        .rsp_err_o       (rsp_err),
        .count_o         (count)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Normal single-precision values only; exact for the operands used here.
    function automatic real sp2real(input logic [31:0] s);
        logic [63:0] d;
        logic [10:0] e;
        if (s[30:0] == 31'd0) return 0.0;
        e = {3'b000, s[30:23]} + 11'd896;
        d = {s[31], e, s[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_calc(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        real ra, rb;
        ra = sp2real(a);
        rb = sp2real(b);
        case (op)
            2'b00:   return real2sp(ra + rb);
            2'b01:   return real2sp(ra - rb);
            2'b10:   return real2sp(ra * rb);
            default: return real2sp(ra / rb);
        endcase
    endfunction

    // FPU model: busy rises one cycle after start (or later in stale mode, with done
    // left high from the previous op); hang mode keeps busy high until released.
    logic        stale_mode = 1'b0;
    logic        hang_mode = 1'b0;
    int          mst, mcnt;
    logic [1:0]  m_op;
    logic [31:0] m_a, m_b;

    always @(posedge clk) begin
        if (fpu_rst) begin
            fpu_busy <= 1'b0;
            fpu_done <= 1'b0;
            fpu_z    <= '0;
            mst      <= 0;
            mcnt     <= 0;
        end else begin
            case (mst)
                0: if (fpu_start) begin
                    mcnt <= 0;
                    if (stale_mode) begin
                        mst <= 1;
                    end else begin
                        fpu_busy <= 1'b1;
                        fpu_done <= 1'b0;
                        mst      <= 2;
                    end
                end
                1: begin
                    mcnt <= mcnt + 1;
                    if (mcnt == 2) begin
                        fpu_busy <= 1'b1;
                        mcnt     <= 0;
                        mst      <= 2;
                    end
                end
                default: begin
                    mcnt <= mcnt + 1;
                    if (mcnt == 0) begin
                        m_op <= fpu_op;
                        m_a  <= fpu_a;
                        m_b  <= fpu_b;
                    end else if (!hang_mode && mcnt >= 3) begin
                        fpu_z    <= fp_calc(m_op, m_a, m_b);
                        fpu_busy <= 1'b0;
                        fpu_done <= 1'b1;
                        mst      <= 0;
                    end
                end
            endcase
        end
    end

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] z;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_rsp = 0;

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check_val("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("rsp_tag", {28'd0, rsp_tag}, {28'd0, e.tag});
                check_val("rsp_z", rsp_z, e.z);
                check_val("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                check_val("rsp_flags", {30'd0, rsp_ovf, rsp_unf}, 32'd0);
                n_rsp++;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the push was accepted.
    task automatic push_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] tag, input logic [31:0] ez, input logic eerr,
                            input bit expect_rsp);
        int guard = 0;
        while (!req_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check_val("push_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        if (expect_rsp) sb.push_back('{tag: tag, z: ez, err: eerr});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int guard = 0;
        while ((sb.size() != 0 || rsp_valid) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check_val(tag, sb.size(), 32'd0);
    endtask

    initial begin
        int guard;
        int n;

        repeat (3) @(negedge clk);
        check_val("rst_start", {31'd0, fpu_start}, 32'd0);
        check_val("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("rst_count", {29'd0, count}, 32'd0);
        check_val("rst_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_z", rsp_z, 32'd0);
        check_val("rst_tag", {28'd0, rsp_tag}, 32'd0);
        check_val("rst_fpu_a", fpu_a, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while waiting on a hung FPU drops the request entirely.
        hang_mode = 1'b1;
        push_req(2'b00, 32'h3F800000, 32'h3F800000, 4'd15, 32'd0, 1'b0, 1'b0);
        guard = 0;
        while (!fpu_start && guard < 50) begin @(negedge clk); guard++; end
        while (fpu_start && guard < 50) begin @(negedge clk); guard++; end
        check_val("t1_reached_wait", {31'd0, fpu_busy}, 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hang_mode = 1'b0;
        check_val("t1_start", {31'd0, fpu_start}, 32'd0);
        check_val("t1_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("t1_count", {29'd0, count}, 32'd0);
        check_val("t1_ready", {31'd0, req_ready}, 32'd1);
        repeat (300) @(negedge clk);

        // Single add, tag 3.
        push_req(2'b00, 32'h3F800000, 32'h40000000, 4'd3, 32'h40400000, 1'b0, 1'b1);
        wait_drain("t2_drain");

        // Hold the first result; queue fills behind it.
        rsp_ready = 1'b0;
        push_req(2'b01, 32'h40A00000, 32'h3FC00000, 4'd5, 32'h40600000, 1'b0, 1'b1);
        guard = 0;
        while (!rsp_valid && guard < 200) begin @(negedge clk); guard++; end
        check_val("t4_valid", {31'd0, rsp_valid}, 32'd1);
        push_req(2'b10, 32'h40000000, 32'h40400000, 4'd0, 32'h40C00000, 1'b0, 1'b1);
        push_req(2'b11, 32'h3F800000, 32'h40800000, 4'd1, 32'h3E800000, 1'b0, 1'b1);
        push_req(2'b01, 32'h40400000, 32'h3F800000, 4'd2, 32'h40000000, 1'b0, 1'b1);
        push_req(2'b00, 32'h3F000000, 32'h3E800000, 4'd3, 32'h3F400000, 1'b0, 1'b1);
        check_val("t3_count_full", {29'd0, count}, 32'd4);
        check_val("t3_ready_full", {31'd0, req_ready}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            check_val("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
            check_val("t4_hold_z", rsp_z, 32'h40600000);
            check_val("t4_hold_tag", {28'd0, rsp_tag}, 32'd5);
            check_val("t4_no_start", {31'd0, fpu_start}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        wait_drain("t3_drain");
        check_val("t3_rsp_count", n_rsp, 32'd6);

        // Done stays high from the previous op while busy is slow to rise.
        stale_mode = 1'b1;
        push_req(2'b00, 32'h40000000, 32'h40000000, 4'd9, 32'h40800000, 1'b0, 1'b1);
        wait_drain("t5_drain");
        stale_mode = 1'b0;

        // Hung FPU: timeout abort, then the next request waits for busy to drop.
        hang_mode = 1'b1;
        push_req(2'b00, 32'h3F800000, 32'h3F800000, 4'd7, 32'h7FC00000, 1'b1, 1'b1);
        push_req(2'b10, 32'h40400000, 32'h40400000, 4'd8, 32'h41100000, 1'b0, 1'b1);
        guard = 0;
        while (!fpu_start && guard < 50) begin @(negedge clk); guard++; end
        while (fpu_start && guard < 50) begin @(negedge clk); guard++; end
        n = 0;
        while (!rsp_valid && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check_val("t6_wait_cycles", n, 32'd255);
        check_val("t6_err", {31'd0, rsp_err}, 32'd1);
        repeat (10) @(negedge clk);
        check_val("t6_held_count", {29'd0, count}, 32'd1);
        check_val("t6_no_start", {31'd0, fpu_start}, 32'd0);
        hang_mode = 1'b0;
        wait_drain("t6_drain");
        check_val("total_rsp", n_rsp, 32'd9);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
